mouse_cfg_sequencer: RTL and testbench
======================================

Name: mouse_cfg_sequencer

Overview:
- Runtime configuration controller for the PS/2 mouse link, placed beside the master state machine.
- Once streaming is running, it takes over the transmitter/receiver byte handshakes. It pauses streaming, issues host-requested commands or the wheel-enable script, checks each ack, then resumes streaming.
- It accepts one request at a time and reports a result code.

Parameters:
- TimeoutCycles, 5000000, per-byte wait limit for BYTE_SENT / ack / ID (50 ms at 100 MHz)
- MaxRetry, 2, resends allowed per byte on 0xFE
- MaxDiscard, 3, stale stream bytes tolerated while waiting for the 0xF5 ack

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CMD_REQ  in  1  level; run a command request; held until DONE
- CMD_BYTE  in  8  command byte, e.g. 0xE8 or 0xF3
- CMD_HAS_ARG  in  1  command takes one argument byte
- CMD_ARG  in  8  argument byte
- WHEEL_REQ  in  1  level; run the IntelliMouse enable script
- SEND_BYTE  out  1  one-cycle pulse to transmitter
- BYTE_TO_SEND  out  8  byte for transmitter; stable from pulse until BYTE_SENT
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver frame error, nonzero = bad
- BYTE_READY  in  1  receiver byte-valid pulse
- BUSY  out  1  sequence active; master SM and position update are gated off
- DONE  out  1  one-cycle completion pulse
- RESULT  out  3  0 ok, 1 timeout, 2 NAK, 3 frame error, 4 unexpected byte; valid at DONE, held until next DONE
- DEVICE_ID  out  8  ID byte returned after 0xF2

Behaviour:
- Reset values: all outputs 0; state IDLE; step, retry and discard counters 0.
  - Reset mid-sequence aborts immediately with no DONE.
  - The byte in flight is abandoned. The transmitter is reset by the same RESET.
- IDLE: requests are sampled only here.
  - WHEEL_REQ beats CMD_REQ when both are high.
  - Acceptance latches CMD_BYTE/CMD_HAS_ARG/CMD_ARG, sets BUSY next cycle, step=0.
- Scripts come from mouse_cfg_script and are indexed by step.
  - Command script: F5, CMD, [ARG], F4.
  - Wheel script: F5, F3, C8, F3, 64, F3, 50, F2(+ID), F4.
- SEND: SEND_BYTE=1 for one cycle with BYTE_TO_SEND=script[step], then go to WAIT_SENT.
- WAIT_SENT: on BYTE_SENT go to WAIT_ACK; the timer restarts on each state entry. Timeout -> error 1.
- WAIT_ACK: READ_ENABLE=1. On BYTE_READY:
  - Frame error -> error 3.
  - 0xFA -> if the step is F2, go to WAIT_ID; else step+1, go to SEND, or to FINISH after the last step.
  - 0xFE -> if retry<MaxRetry, retry+1 and resend the same step; else error 2. Retry clears on step advance.
  - 0xFC -> error 2.
  - Other byte at step 0 -> discard; discard+1; error 4 when discard would exceed MaxDiscard.
  - Other byte at any later step -> error 4.
  - Timeout -> error 1.
- WAIT_ID: READ_ENABLE=1; first BYTE_READY loads DEVICE_ID (0x03 = wheel present), step+1, go to SEND. Frame error -> error 3; timeout -> error 1.
- Error handling:
  - After step 0 is acked, the first error is latched and the sequencer jumps to the final F4 step (RECOVER), sent once with no retries. RESULT reports the first error.
  - An error at step 0 or during RECOVER goes straight to FINISH.
- FINISH: DONE=1 and RESULT valid in the same cycle; BUSY drops the next cycle; return to IDLE.
  - A request still held high during the DONE cycle is not re-accepted until the cycle after BUSY drops.
  - Requesters must lower the request on DONE.
- Simultaneous BYTE_READY and timeout in the same cycle: BYTE_READY wins.
- Timer: 23-bit counter, saturating, compared against TimeoutCycles-1.

Decomposition:
- Shared package holds:
  - PS/2 constants: ACK=FA, RESEND=FE, ERROR=FC, DISABLE=F5, ENABLE=F4, SETRATE=F3, GETID=F2.
  - RESULT code localparams.
  - State encoding.
- Sub-module mouse_cfg_script: combinational ROM. Inputs are script select, step, and the latched command fields. Outputs are byte, is_last, is_getid.

Test Plan:
- CMD_REQ E8/arg 02; model acks every byte with FA -> bytes F5,E8,02,F4 sent in order; one DONE with RESULT=0; BUSY high from the cycle after acceptance through DONE.
- WHEEL_REQ; model acks all bytes and returns ID 03 after F2's FA -> 9 bytes sent; DEVICE_ID=03; RESULT=0.
- CMD_REQ F3/arg 28; model answers the first 0x28 with FE twice, then FA -> 0x28 sent 3 times; RESULT=0. Repeat with three FE -> RESULT=2, followed by F4 sent and acked.
- Model injects 2 stream bytes (0x08, 0x01) before acking F5 -> both discarded; RESULT=0. Repeat with 4 bytes -> RESULT=4, F4 not sent.
- Model never asserts BYTE_READY after CMD byte E6 -> timeout at TimeoutCycles (use 100 in sim); F4 recovery sent; RESULT=1.
- CMD_REQ and WHEEL_REQ raised together -> wheel script runs first. RESET asserted mid-WAIT_ACK -> all outputs 0 the next cycle, no DONE pulse.

Source files
------------

// File: rtl/mouse_cfg_sequencer_pkg.sv
// Shared definitions for the PS/2 mouse configuration sequencer: protocol bytes,
// result codes, state encoding and script geometry.
package mouse_cfg_sequencer_pkg;

    localparam logic [7:0] Ps2Ack     = 8'hFA;
    localparam logic [7:0] Ps2Resend  = 8'hFE;
    localparam logic [7:0] Ps2Error   = 8'hFC;
    localparam logic [7:0] Ps2Disable = 8'hF5;
    localparam logic [7:0] Ps2Enable  = 8'hF4;
    localparam logic [7:0] Ps2SetRate = 8'hF3;
    localparam logic [7:0] Ps2GetId   = 8'hF2;

    localparam logic [2:0] ResOk         = 3'd0;
    localparam logic [2:0] ResTimeout    = 3'd1;
    localparam logic [2:0] ResNak        = 3'd2;
    localparam logic [2:0] ResFrame      = 3'd3;
    localparam logic [2:0] ResUnexpected = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitSent,
        StWaitAck,
        StWaitId,
        StFinish
    } seqState_t;

    typedef enum logic {
        ScriptCmd,
        ScriptWheel
    } scriptSel_t;

    localparam int StepWidth = 4;
    typedef logic [StepWidth-1:0] step_t;

    // Index of the closing F4 step; also the jump target when recovering from an error.
    function automatic step_t lastStep(scriptSel_t sel, logic hasArg);
        if (sel == ScriptWheel) return step_t'(8);
        return hasArg ? step_t'(3) : step_t'(2);
    endfunction

endpackage

// File: rtl/mouse_cfg_sequencer_if.sv
// Host request/result and transmitter/receiver handshake signals of the
// configuration sequencer, bundled for the master (host/link) and slave (sequencer) sides.
interface mouse_cfg_sequencer_if;

    logic       CMD_REQ;
    logic [7:0] CMD_BYTE;
    logic       CMD_HAS_ARG;
    logic [7:0] CMD_ARG;
    logic       WHEEL_REQ;

    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    logic       BUSY;
    logic       DONE;
    logic [2:0] RESULT;
    logic [7:0] DEVICE_ID;

    modport slave (
        input  CMD_REQ, CMD_BYTE, CMD_HAS_ARG, CMD_ARG, WHEEL_REQ,
        input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
        output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        output BUSY, DONE, RESULT, DEVICE_ID
    );

    modport master (
        output CMD_REQ, CMD_BYTE, CMD_HAS_ARG, CMD_ARG, WHEEL_REQ,
        output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
        input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        input  BUSY, DONE, RESULT, DEVICE_ID
    );

endinterface

// File: rtl/mouse_cfg_script.sv
// Combinational script ROM: maps (script, step) to the byte to transmit and
// flags the closing step and the step whose ack is followed by an ID byte.
module mouse_cfg_script
    import mouse_cfg_sequencer_pkg::*;
(
    input  scriptSel_t scriptSel,
    input  step_t      step,
    input  logic [7:0] cmdByte,
    input  logic       hasArg,
    input  logic [7:0] cmdArg,
    output logic [7:0] scriptByte,
    output logic       isLast,
    output logic       isGetid
);

    always_comb begin
        scriptByte = Ps2Enable;
        if (scriptSel == ScriptWheel) begin
            // Sample rates 200, 100, 80 is the IntelliMouse unlock knock.
            case (step)
                step_t'(0): scriptByte = Ps2Disable;
                step_t'(1): scriptByte = Ps2SetRate;
                step_t'(2): scriptByte = 8'hC8;
                step_t'(3): scriptByte = Ps2SetRate;
                step_t'(4): scriptByte = 8'h64;
                step_t'(5): scriptByte = Ps2SetRate;
                step_t'(6): scriptByte = 8'h50;
                step_t'(7): scriptByte = Ps2GetId;
                default:    scriptByte = Ps2Enable;
            endcase
        end else begin
            case (step)
                step_t'(0): scriptByte = Ps2Disable;
                step_t'(1): scriptByte = cmdByte;
                step_t'(2): scriptByte = hasArg ? cmdArg : Ps2Enable;
                default:    scriptByte = Ps2Enable;
            endcase
        end
        isLast  = (step == lastStep(scriptSel, hasArg));
        isGetid = (scriptSel == ScriptWheel) && (step == step_t'(7));
    end

endmodule

// File: rtl/mouse_cfg_sequencer.sv
// Runtime PS/2 mouse configuration sequencer: pauses streaming, plays a command
// or wheel-enable script with ack checking, retries and recovery, then resumes.
module mouse_cfg_sequencer
    import mouse_cfg_sequencer_pkg::*;
#(
    parameter int TimeoutCycles = 5000000,
    parameter int MaxRetry      = 2,
    parameter int MaxDiscard    = 3
) (
    input  logic                        CLK,
    input  logic                        RESET,
    mouse_cfg_sequencer_if.slave        bus
);

    localparam logic [22:0] TimerLimit = 23'(TimeoutCycles - 1);

    seqState_t  state, stateNext;
    step_t      step, stepNext;
    logic [3:0] retryCnt, retryNext;
    logic [3:0] discardCnt, discardNext;
    logic       recovering, recoverNext;
    logic [2:0] firstErr, firstErrNext;
    logic [2:0] resultQ, resultNext;
    logic [7:0] deviceIdQ, deviceIdNext;
    scriptSel_t scriptSel, selNext;
    logic [7:0] cmdByteQ, cmdByteNext;
    logic       hasArgQ, hasArgNext;
    logic [7:0] cmdArgQ, cmdArgNext;
    logic [22:0] timer;

    logic       timeout;
    logic       raiseErr;
    logic [2:0] errCode;
    logic [7:0] scriptByte;
    logic       isLast, isGetid;

    mouse_cfg_script scriptRom (
        .scriptSel (scriptSel),
        .step      (step),
        .cmdByte   (cmdByteQ),
        .hasArg    (hasArgQ),
        .cmdArg    (cmdArgQ),
        .scriptByte(scriptByte),
        .isLast    (isLast),
        .isGetid   (isGetid)
    );

    assign timeout = (timer == TimerLimit);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        stateNext    = state;
        stepNext     = step;
        retryNext    = retryCnt;
        discardNext  = discardCnt;
        recoverNext  = recovering;
        firstErrNext = firstErr;
        resultNext   = resultQ;
        deviceIdNext = deviceIdQ;
        selNext      = scriptSel;
        cmdByteNext  = cmdByteQ;
        hasArgNext   = hasArgQ;
        cmdArgNext   = cmdArgQ;
        raiseErr     = 1'b0;
        errCode      = ResOk;

        case (state)
            StIdle: begin
                stepNext     = '0;
                retryNext    = '0;
                discardNext  = '0;
                recoverNext  = 1'b0;
                firstErrNext = ResOk;
                if (bus.WHEEL_REQ || bus.CMD_REQ) begin
                    selNext     = bus.WHEEL_REQ ? ScriptWheel : ScriptCmd;
                    cmdByteNext = bus.CMD_BYTE;
                    hasArgNext  = bus.CMD_HAS_ARG;
                    cmdArgNext  = bus.CMD_ARG;
                    stateNext   = StSend;
                end
            end
            StSend: stateNext = StWaitSent;
            StWaitSent: begin
                if (bus.BYTE_SENT) begin
                    stateNext = StWaitAck;
                end else if (timeout) begin
                    raiseErr = 1'b1;
                    errCode  = ResTimeout;
                end
            end
            StWaitAck: begin
                // A byte arriving on the timeout cycle is still honoured.
                if (bus.BYTE_READY) begin
                    if (bus.BYTE_ERROR_CODE != 2'd0) begin
                        raiseErr = 1'b1;
                        errCode  = ResFrame;
                    end else if (bus.BYTE_READ == Ps2Ack) begin
                        retryNext = '0;
                        if (isGetid) begin
                            stateNext = StWaitId;
                        end else if (isLast) begin
                            stateNext  = StFinish;
                            resultNext = recovering ? firstErr : ResOk;
                        end else begin
                            stepNext  = step + step_t'(1);
                            stateNext = StSend;
                        end
                    end else if (bus.BYTE_READ == Ps2Resend) begin
                        if (!recovering && retryCnt < 4'(MaxRetry)) begin
                            retryNext = retryCnt + 4'd1;
                            stateNext = StSend;
                        end else begin
                            raiseErr = 1'b1;
                            errCode  = ResNak;
                        end
                    end else if (bus.BYTE_READ == Ps2Error) begin
                        raiseErr = 1'b1;
                        errCode  = ResNak;
                    end else if (step == '0) begin
                        // Movement packets already in flight before the F5 took effect.
                        if (discardCnt == 4'(MaxDiscard)) begin
                            raiseErr = 1'b1;
                            errCode  = ResUnexpected;
                        end else begin
                            discardNext = discardCnt + 4'd1;
                        end
                    end else begin
                        raiseErr = 1'b1;
                        errCode  = ResUnexpected;
                    end
                end else if (timeout) begin
                    raiseErr = 1'b1;
                    errCode  = ResTimeout;
                end
            end
            StWaitId: begin
                if (bus.BYTE_READY) begin
                    if (bus.BYTE_ERROR_CODE != 2'd0) begin
                        raiseErr = 1'b1;
                        errCode  = ResFrame;
                    end else begin
                        deviceIdNext = bus.BYTE_READ;
                        stepNext     = step + step_t'(1);
                        stateNext    = StSend;
                    end
                end else if (timeout) begin
                    raiseErr = 1'b1;
                    errCode  = ResTimeout;
                end
            end
            StFinish: stateNext = StIdle;
            default:  stateNext = StIdle;
        endcase

        // Once streaming is disabled, always try to re-enable it before reporting.
        if (raiseErr) begin
            if (step == '0 || recovering) begin
                stateNext  = StFinish;
                resultNext = recovering ? firstErr : errCode;
            end else begin
                firstErrNext = errCode;
                recoverNext  = 1'b1;
                stepNext     = lastStep(scriptSel, hasArgQ);
                retryNext    = '0;
                stateNext    = StSend;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= StIdle;
            step       <= '0;
            retryCnt   <= '0;
            discardCnt <= '0;
            recovering <= 1'b0;
            firstErr   <= ResOk;
            resultQ    <= ResOk;
            deviceIdQ  <= 8'h00;
            scriptSel  <= ScriptCmd;
            cmdByteQ   <= 8'h00;
            hasArgQ    <= 1'b0;
            cmdArgQ    <= 8'h00;
            timer      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state      <= stateNext;
            step       <= stepNext;
            retryCnt   <= retryNext;
            discardCnt <= discardNext;
            recovering <= recoverNext;
            firstErr   <= firstErrNext;
            resultQ    <= resultNext;
            deviceIdQ  <= deviceIdNext;
            scriptSel  <= selNext;
            cmdByteQ   <= cmdByteNext;
            hasArgQ    <= hasArgNext;
            cmdArgQ    <= cmdArgNext;
            if (stateNext != state) timer <= '0;
            else if (timer != '1)   timer <= timer + 23'd1;
        end
    end

    assign bus.SEND_BYTE    = (state == StSend);
    assign bus.BYTE_TO_SEND = (state == StSend || state == StWaitSent) ? scriptByte : 8'h00;
    assign bus.READ_ENABLE  = (state == StWaitAck || state == StWaitId);
    assign bus.BUSY         = (state != StIdle);
    assign bus.DONE         = (state == StFinish);
    assign bus.RESULT       = resultQ;
    assign bus.DEVICE_ID    = deviceIdQ;

endmodule

// File: tb/tb_mouse_cfg_sequencer.sv
// Directed bench for mouse_cfg_sequencer: plays the transmitter/receiver side of
// the PS/2 link step by step and checks bytes, results and handshakes.
module tb_mouse_cfg_sequencer;

    logic CLK;
    logic RESET;
    int   vectors;
    int   miscompares;

    mouse_cfg_sequencer_if bus ();

    mouse_cfg_sequencer #(
        .TimeoutCycles(100),
        .MaxRetry     (2),
        .MaxDiscard   (3)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, " SEND_BYTE"},    32'(bus.SEND_BYTE),    32'd0);
        check({tag, " BYTE_TO_SEND"}, 32'(bus.BYTE_TO_SEND), 32'd0);
        check({tag, " READ_ENABLE"},  32'(bus.READ_ENABLE),  32'd0);
        check({tag, " BUSY"},         32'(bus.BUSY),         32'd0);
        check({tag, " DONE"},         32'(bus.DONE),         32'd0);
        check({tag, " RESULT"},       32'(bus.RESULT),       32'd0);
        check({tag, " DEVICE_ID"},    32'(bus.DEVICE_ID),    32'd0);
    endtask

    task automatic startReq(input string tag, input logic wheel, input logic cmd,
                            input logic [7:0] cmdByte, input logic hasArg, input logic [7:0] arg);
        bus.CMD_BYTE    = cmdByte;
        bus.CMD_HAS_ARG = hasArg;
        bus.CMD_ARG     = arg;
        bus.CMD_REQ     = cmd;
        bus.WHEEL_REQ   = wheel;
        @(negedge CLK);
        check({tag, " busy after accept"}, 32'(bus.BUSY), 32'd1);
    endtask

    task automatic waitSend(input string tag, input logic [7:0] expByte, input int budget,
                            output int waited);
        waited = 0;
        while (!bus.SEND_BYTE && waited < budget) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, " send pulse"}, 32'(bus.SEND_BYTE), 32'd1);
        check({tag, " byte"}, 32'(bus.BYTE_TO_SEND), 32'(expByte));
    endtask

    task automatic pulseSent();
        @(negedge CLK);
        bus.BYTE_SENT = 1'b1;
        @(negedge CLK);
        bus.BYTE_SENT = 1'b0;
    endtask

    task automatic respond(input string tag, input logic [7:0] rxByte, input logic [1:0] err);
        check({tag, " read enable"}, 32'(bus.READ_ENABLE), 32'd1);
        bus.BYTE_READ       = rxByte;
        bus.BYTE_ERROR_CODE = err;
        bus.BYTE_READY      = 1'b1;
        @(negedge CLK);
        bus.BYTE_READY      = 1'b0;
        bus.BYTE_ERROR_CODE = 2'd0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] expByte, input logic [7:0] rxByte);
        int waited;
        waitSend(tag, expByte, 20, waited);
        pulseSent();
        respond(tag, rxByte, 2'd0);
    endtask

    task automatic waitDone(input string tag, input logic [2:0] expResult);
        int n = 0;
        bit sawSend = 1'b0;
        while (!bus.DONE && n < 20) begin
            if (bus.SEND_BYTE) sawSend = 1'b1;
            @(negedge CLK);
            n++;
        end
        check({tag, " done pulse"}, 32'(bus.DONE), 32'd1);
        check({tag, " result"}, 32'(bus.RESULT), 32'(expResult));
        check({tag, " busy at done"}, 32'(bus.BUSY), 32'd1);
        check({tag, " no extra send"}, 32'(sawSend), 32'd0);
        bus.CMD_REQ   = 1'b0;
        bus.WHEEL_REQ = 1'b0;
        @(negedge CLK);
        check({tag, " busy dropped"}, 32'(bus.BUSY), 32'd0);
        check({tag, " done single"}, 32'(bus.DONE), 32'd0);
    endtask

    initial begin
        logic [7:0] wheelBytes [8];
        int waited;
        bit sawDone;

        wheelBytes = '{8'hF5, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2};
        vectors             = 0;
        miscompares         = 0;
        RESET               = 1'b1;
        bus.CMD_REQ         = 1'b0;
        bus.CMD_BYTE        = 8'h00;
        bus.CMD_HAS_ARG     = 1'b0;
        bus.CMD_ARG         = 8'h00;
        bus.WHEEL_REQ       = 1'b0;
        bus.BYTE_SENT       = 1'b0;
        bus.BYTE_READ       = 8'h00;
        bus.BYTE_ERROR_CODE = 2'd0;
        bus.BYTE_READY      = 1'b0;
        repeat (3) @(negedge CLK);
        checkIdleOutputs("reset");
        RESET = 1'b0;
        @(negedge CLK);

        // Plain command with argument, every byte acked.
        startReq("cmdE8", 1'b0, 1'b1, 8'hE8, 1'b1, 8'h02);
        xfer("cmdE8 F5", 8'hF5, 8'hFA);
        xfer("cmdE8 E8", 8'hE8, 8'hFA);
        xfer("cmdE8 02", 8'h02, 8'hFA);
        xfer("cmdE8 F4", 8'hF4, 8'hFA);
        waitDone("cmdE8", 3'd0);

        // Wheel script with ID 03 after the F2 ack.
        startReq("wheel", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) xfer("wheel step", wheelBytes[i], 8'hFA);
        respond("wheel id", 8'h03, 2'd0);
        xfer("wheel F4", 8'hF4, 8'hFA);
        waitDone("wheel", 3'd0);
        check("wheel device id", 32'(bus.DEVICE_ID), 32'h03);

        // Two resends on the argument byte are absorbed.
        startReq("retry2", 1'b0, 1'b1, 8'hF3, 1'b1, 8'h28);
        xfer("retry2 F5", 8'hF5, 8'hFA);
        xfer("retry2 F3", 8'hF3, 8'hFA);
        xfer("retry2 28a", 8'h28, 8'hFE);
        xfer("retry2 28b", 8'h28, 8'hFE);
        xfer("retry2 28c", 8'h28, 8'hFA);
        xfer("retry2 F4", 8'hF4, 8'hFA);
        waitDone("retry2", 3'd0);

        // A third resend is a NAK; streaming is still re-enabled.
        startReq("retry3", 1'b0, 1'b1, 8'hF3, 1'b1, 8'h28);
        xfer("retry3 F5", 8'hF5, 8'hFA);
        xfer("retry3 F3", 8'hF3, 8'hFA);
        xfer("retry3 28a", 8'h28, 8'hFE);
        xfer("retry3 28b", 8'h28, 8'hFE);
        xfer("retry3 28c", 8'h28, 8'hFE);
        xfer("retry3 F4", 8'hF4, 8'hFA);
        waitDone("retry3", 3'd2);

        // Two stale stream bytes before the F5 ack are discarded.
        startReq("disc2", 1'b0, 1'b1, 8'hE8, 1'b1, 8'h02);
        waitSend("disc2 F5", 8'hF5, 20, waited);
        pulseSent();
        respond("disc2 s1", 8'h08, 2'd0);
        respond("disc2 s2", 8'h01, 2'd0);
        respond("disc2 ack", 8'hFA, 2'd0);
        xfer("disc2 E8", 8'hE8, 8'hFA);
        xfer("disc2 02", 8'h02, 8'hFA);
        xfer("disc2 F4", 8'hF4, 8'hFA);
        waitDone("disc2", 3'd0);

        // A fourth stale byte exceeds the allowance: unexpected byte, no F4.
        startReq("disc4", 1'b0, 1'b1, 8'hE8, 1'b1, 8'h02);
        waitSend("disc4 F5", 8'hF5, 20, waited);
        pulseSent();
        respond("disc4 s1", 8'h08, 2'd0);
        respond("disc4 s2", 8'h01, 2'd0);
        respond("disc4 s3", 8'h08, 2'd0);
        respond("disc4 s4", 8'h01, 2'd0);
        waitDone("disc4", 3'd4);

        // Silent device after E6: timeout after 100 cycles, then F4 recovery.
        startReq("tmo", 1'b0, 1'b1, 8'hE6, 1'b0, 8'h00);
        xfer("tmo F5", 8'hF5, 8'hFA);
        waitSend("tmo E6", 8'hE6, 20, waited);
        pulseSent();
        waitSend("tmo F4", 8'hF4, 300, waited);
        check("tmo wait cycles", 32'(waited), 32'd100);
        pulseSent();
        respond("tmo F4", 8'hFA, 2'd0);
        waitDone("tmo", 3'd1);

        // Both requests together: wheel script wins.
        startReq("both", 1'b1, 1'b1, 8'hE8, 1'b1, 8'h02);
        for (int i = 0; i < 8; i++) xfer("both step", wheelBytes[i], 8'hFA);
        respond("both id", 8'h04, 2'd0);
        xfer("both F4", 8'hF4, 8'hFA);
        waitDone("both", 3'd0);
        check("both device id", 32'(bus.DEVICE_ID), 32'h04);

        // Reset while waiting for the F5 ack aborts silently.
        startReq("rst", 1'b0, 1'b1, 8'hE8, 1'b1, 8'h02);
        waitSend("rst F5", 8'hF5, 20, waited);
        pulseSent();
        check("rst in wait ack", 32'(bus.READ_ENABLE), 32'd1);
        RESET       = 1'b1;
        bus.CMD_REQ = 1'b0;
        @(negedge CLK);
        checkIdleOutputs("rst abort");
        sawDone = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (bus.DONE) sawDone = 1'b1;
        end
        RESET = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (bus.DONE || bus.BUSY) sawDone = 1'b1;
        end
        check("rst no done", 32'(sawDone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
